// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction-fetch and
// data-access requesters. Round-robin on ties, a single transaction in
// flight, and a bus timeout that completes the transaction with an error.
// Every output is driven straight from a flop.
module mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch side
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  // data access side
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // memory side
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // Counter value seen in the last tolerated wait cycle: TIMEOUT waits total.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  owner_t      last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;

  logic        i_ack_q, i_ack_d;
  logic        i_err_q, i_err_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        d_ack_q, d_ack_d;
  logic        d_err_q, d_err_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        pick_data;

  // Arbitration: data wins when alone, or on a tie when fetch was served last.
  always_comb begin
    pick_data = d_req && (!i_req || (last_grant_q == OWN_FETCH));
  end

  // Next-state and output computation for the IDLE/BUSY/RESP sequence.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    i_ack_d      = i_ack_q;
    i_err_d      = i_err_q;
    i_rdata_d    = i_rdata_q;
    d_ack_d      = d_ack_q;
    d_err_d      = d_err_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d   = ST_BUSY;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          if (pick_data) begin
            owner_d      = OWN_DATA;
            last_grant_d = OWN_DATA;
            mem_wen_d    = d_wen;
            mem_addr_d   = d_addr;
            mem_wdata_d  = d_wdata;
            // Byte enables only mean something on writes.
            mem_wstrb_d  = d_wen ? d_wstrb : 4'b0000;
          end else begin
            owner_d      = OWN_FETCH;
            last_grant_d = OWN_FETCH;
            mem_wen_d    = 1'b0;
            mem_addr_d   = i_addr;
            mem_wdata_d  = 32'h0;
            mem_wstrb_d  = 4'b0000;
          end
        end
      end

      ST_BUSY: begin
        // A ready in the last tolerated cycle still counts as a normal finish.
        if (mem_ready) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (owner_q == OWN_DATA) begin
            d_ack_d   = 1'b1;
            d_err_d   = 1'b0;
            d_rdata_d = mem_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_err_d   = 1'b0;
            i_rdata_d = mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (owner_q == OWN_DATA) begin
            d_ack_d   = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = 32'h0;
          end else begin
            i_ack_d   = 1'b1;
            i_err_d   = 1'b1;
            i_rdata_d = 32'h0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        // Response is visible for this single cycle; requests wait for IDLE.
        state_d = ST_IDLE;
        i_ack_d = 1'b0;
        i_err_d = 1'b0;
        d_ack_d = 1'b0;
        d_err_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_FETCH;
      last_grant_q <= OWN_FETCH;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      i_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      i_rdata_q    <= 32'h0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      i_ack_q      <= i_ack_d;
      i_err_q      <= i_err_d;
      i_rdata_q    <= i_rdata_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wen;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wstrb;
  logic        i_ack, i_err, d_ack, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_wen, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;

  // memory responder: ready after mem_wait wait cycles, never when stuck
  int mem_wait = 0;
  bit stuck = 1'b0;
  int wcnt = 0;

  mem_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  assign mem_ready = mem_req && !stuck && (wcnt == mem_wait);

  always @(posedge clk) begin
    if (!mem_req || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_busy, m_resp, m_own, m_last;
  int          m_waited;
  logic        e_mem_req, e_mem_wen, e_i_ack, e_i_err, e_d_ack, e_d_err;
  logic [31:0] e_mem_addr, e_mem_wdata, e_i_rdata, e_d_rdata;
  logic [3:0]  e_mem_wstrb;

  task automatic model_finish(input bit err, input logic [31:0] data);
    m_busy = 1'b0;
    m_resp = 1'b1;
    e_mem_req = 1'b0;
    if (m_own) begin e_d_ack = 1'b1; e_d_err = err; e_d_rdata = data; end
    else       begin e_i_ack = 1'b1; e_i_err = err; e_i_rdata = data; end
  endtask

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_resp = 0; m_last = 0; m_own = 0; m_waited = 0;
      e_mem_req = 0; e_mem_wen = 0; e_mem_addr = 0; e_mem_wdata = 0; e_mem_wstrb = 0;
      e_i_ack = 0; e_i_err = 0; e_i_rdata = 0; e_d_ack = 0; e_d_err = 0; e_d_rdata = 0;
    end else if (m_resp) begin
      m_resp = 0;
      e_i_ack = 0; e_i_err = 0; e_d_ack = 0; e_d_err = 0;
    end else if (!m_busy) begin
      if (i_req || d_req) begin
        m_own = (i_req && d_req) ? !m_last : d_req;
        m_last = m_own;
        m_busy = 1; m_waited = 0;
        e_mem_req = 1;
        if (m_own) begin
          e_mem_wen = d_wen; e_mem_addr = d_addr; e_mem_wdata = d_wdata;
          e_mem_wstrb = d_wen ? d_wstrb : 4'b0000;
        end else begin
          e_mem_wen = 0; e_mem_addr = i_addr; e_mem_wdata = 0; e_mem_wstrb = 0;
        end
      end
    end else begin
      m_waited++;
      if (mem_ready) model_finish(1'b0, mem_rdata);
      else if (m_waited >= TMO) model_finish(1'b1, 32'h0);
    end
  endtask

  // compare process: model advances on the edge, outputs checked mid-cycle
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("mem_req",   mem_req,   e_mem_req);
      chk("mem_wen",   mem_wen,   e_mem_wen);
      chk("mem_addr",  mem_addr,  e_mem_addr);
      chk("mem_wdata", mem_wdata, e_mem_wdata);
      chk("mem_wstrb", mem_wstrb, e_mem_wstrb);
      chk("i_ack",     i_ack,     e_i_ack);
      chk("i_err",     i_err,     e_i_err);
      chk("i_rdata",   i_rdata,   e_i_rdata);
      chk("d_ack",     d_ack,     e_d_ack);
      chk("d_err",     d_err,     e_d_err);
      chk("d_rdata",   d_rdata,   e_d_rdata);
      chk("ack_exclusive", i_ack & d_ack, 1'b0);
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic ev(input int which);
    case (which)
      0: ev = i_ack;
      1: ev = d_ack;
      default: ev = mem_req;
    endcase
  endfunction

  // waits (bounded) until the selected signal is high at a negedge
  task automatic wait_ev(input int which, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ev(which) && n < 100);
  endtask

  int n, n2, acks, req_cyc;
  bit prev;
  bit order[$];
  bit exp_ord[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1; i_req = 1; d_req = 1; d_wen = 0;
    i_addr = 32'h40; d_addr = 32'h80; d_wdata = 0; d_wstrb = 0;
    mem_rdata = 32'h11110000;

    // reset held two cycles with both requests up
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_acks", {i_ack, d_ack}, 2'b00);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst = 0;

    // contention: both held, four transactions
    n = 0; acks = 0; prev = 0;
    while (acks < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (mem_req && !prev) order.push_back(mem_addr == 32'h80);
      prev = mem_req;
      if (i_ack || d_ack) begin
        acks++;
        mem_rdata = mem_rdata + 32'h1;
      end
    end
    i_req = 0; d_req = 0;
    chk("contention_acks", acks, 4);
    chk("contention_cycles", n, 11);
    chk("grant_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk($sformatf("grant_order%0d", i), order[i], exp_ord[i]);
    @(negedge clk);

    // single fetch, ready in the first request cycle
    i_addr = 32'h100; mem_rdata = 32'h00500093; mem_wait = 0; i_req = 1;
    wait_ev(2, n);
    chk("fetch_mem_addr", mem_addr, 32'h100);
    chk("fetch_mem_wen", mem_wen, 1'b0);
    wait_ev(0, n2);
    chk("fetch_ack_latency", n + n2, 2);
    chk("fetch_rdata", i_rdata, 32'h00500093);
    chk("fetch_err", i_err, 1'b0);
    i_req = 0;
    @(negedge clk);

    // write with three wait cycles
    d_wen = 1; d_addr = 32'h2000; d_wdata = 32'hBEEFBEEF; d_wstrb = 4'b0011;
    mem_wait = 3; mem_rdata = 32'hCAFE0001; d_req = 1;
    n = 0; req_cyc = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_req) begin
        req_cyc++;
        chk("write_wen", mem_wen, 1'b1);
        chk("write_addr", mem_addr, 32'h2000);
        chk("write_wdata", mem_wdata, 32'hBEEFBEEF);
        chk("write_wstrb", mem_wstrb, 4'b0011);
      end
    end while (!d_ack && n < 100);
    chk("write_ack", d_ack, 1'b1);
    chk("write_req_cycles", req_cyc, 4);
    chk("write_err", d_err, 1'b0);
    chk("write_rdata", d_rdata, 32'hCAFE0001);
    d_req = 0; d_wen = 0;
    @(negedge clk);
    chk("write_ack_pulse", d_ack, 1'b0);

    // timeout on a fetch
    stuck = 1; mem_rdata = 32'hDEADBEEF; i_addr = 32'h300; i_req = 1;
    n = 0; req_cyc = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_req) req_cyc++;
    end while (!i_ack && n < 100);
    chk("tmo_ack", i_ack, 1'b1);
    chk("tmo_req_cycles", req_cyc, TMO);
    chk("tmo_err", i_err, 1'b1);
    chk("tmo_rdata", i_rdata, 32'h0);
    i_req = 0; stuck = 0;

    // following data read completes normally; strobes suppressed on reads
    d_addr = 32'h44; d_wstrb = 4'hF; d_wen = 0; d_wdata = 0;
    mem_wait = 1; mem_rdata = 32'h12345678; d_req = 1;
    wait_ev(2, n);
    chk("read_wstrb", mem_wstrb, 4'b0000);
    chk("read_addr", mem_addr, 32'h44);
    wait_ev(1, n);
    chk("read_rdata", d_rdata, 32'h12345678);
    chk("read_err", d_err, 1'b0);
    d_req = 0;
    @(negedge clk);

    // reset while a transaction is waiting on memory
    stuck = 1; d_addr = 32'h500; d_req = 1;
    wait_ev(2, n);
    rst = 1;
    @(negedge clk);
    chk("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_ack", {i_ack, d_ack}, 2'b00);
    rst = 0; d_req = 0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_quiet", {mem_req, i_ack, d_ack}, 3'b000);
    end

    // first tie after that reset goes to data again
    stuck = 0; mem_wait = 0; i_addr = 32'h600; d_addr = 32'h700;
    i_req = 1; d_req = 1;
    wait_ev(2, n);
    chk("tie_after_rst", mem_addr, 32'h700);
    wait_ev(1, n);
    chk("tie_d_ack", d_ack, 1'b1);
    d_req = 0;
    wait_ev(0, n);
    chk("tie_i_ack", i_ack, 1'b1);
    i_req = 0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
